// File: rtl/scores_uart_readout_pkg.sv
//------------------------------------------------------------------------------
// Module  : scores_uart_readout_pkg
// Brief   : Shared constants and FSM encoding for the result-frame readout.
//           Optional macro READOUT_CHECKSUM_EN adds a trailing XOR byte.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package scores_uart_readout_pkg;

  localparam int c_NUM_CLASSES      = 10;
  localparam int c_BYTES_PER_SCORE  = 4;
  localparam int c_SCORES_RAM_DEPTH = c_NUM_CLASSES * c_BYTES_PER_SCORE;

`ifdef READOUT_CHECKSUM_EN
  localparam int c_FRAME_LEN = c_SCORES_RAM_DEPTH + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4,
    CKSUM = 3'd5
  } state_t;
`else
  localparam int c_FRAME_LEN = c_SCORES_RAM_DEPTH + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/scores_uart_readout_if.sv
//------------------------------------------------------------------------------
// Module  : scores_uart_readout_if
// Brief   : Control, result-RAM read ports and UART byte stream of the readout.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface scores_uart_readout_if #(
  parameter int ADDR_W = 6
);

  logic              start;
  logic              busy;
  logic              done;
  logic              digit_rd_addr;
  logic [7:0]        digit_rd_data;
  logic [ADDR_W-1:0] scores_rd_addr;
  logic [7:0]        scores_rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start,
    output busy,
    output done,
    output digit_rd_addr,
    input  digit_rd_data,
    output scores_rd_addr,
    input  scores_rd_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  digit_rd_addr,
    output digit_rd_data,
    input  scores_rd_addr,
    output scores_rd_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

`default_nettype wire

// File: rtl/scores_uart_readout.sv
//------------------------------------------------------------------------------
// Module  : scores_uart_readout
// Brief   : Streams digit byte + little-endian class scores to the UART on start.
//           READOUT_CHECKSUM_EN appends the XOR of all preceding frame bytes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scores_uart_readout
  import scores_uart_readout_pkg::*;
#(
  parameter int NUM_CLASSES     = c_NUM_CLASSES,
  parameter int BYTES_PER_SCORE = c_BYTES_PER_SCORE,
  parameter int ADDR_W          = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  scores_uart_readout_if.master bus
);

  // idx 0 is the digit byte; idx k>=1 is scores RAM address k-1
  localparam int c_LAST_RAM_IDX = NUM_CLASSES * BYTES_PER_SCORE;
`ifdef READOUT_CHECKSUM_EN
  localparam int c_NUM_IDX      = c_LAST_RAM_IDX + 2;
`else
  localparam int c_NUM_IDX      = c_LAST_RAM_IDX + 1;
`endif
  localparam int c_IDX_W        = $clog2(c_NUM_IDX);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_LAST_RAM_IDX);
`ifdef READOUT_CHECKSUM_EN
  localparam logic [c_IDX_W-1:0] c_CKSUM_IDX = c_IDX_W'(c_LAST_RAM_IDX + 1);
`endif

  state_t              r_state;
  logic [c_IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0]   r_scores_addr;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_done;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]          r_cksum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_scores_addr <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      r_cksum       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_idx         <= '0;
            r_scores_addr <= '0;
            r_busy        <= 1'b1;
            r_state       <= FETCH;
`ifdef READOUT_CHECKSUM_EN
            r_cksum       <= '0;
`endif
          end
        end
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_tx_data  <= (r_idx == '0) ? bus.digit_rd_data : bus.scores_rd_data;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end
`ifdef READOUT_CHECKSUM_EN
        CKSUM: begin
          r_tx_data  <= r_cksum;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end
`endif
        SEND: begin
          if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            r_cksum    <= r_cksum ^ r_tx_data;
            if (r_idx == c_CKSUM_IDX) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (r_idx == c_LAST_IDX) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= CKSUM;
            end else begin
              r_idx         <= r_idx + 1'b1;
              r_scores_addr <= ADDR_W'(r_idx);
              r_state       <= FETCH;
            end
`else
            if (r_idx == c_LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              // next idx is r_idx+1, whose RAM address is the current r_idx
              r_idx         <= r_idx + 1'b1;
              r_scores_addr <= ADDR_W'(r_idx);
              r_state       <= FETCH;
            end
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.digit_rd_addr  = 1'b0;
  assign bus.scores_rd_addr = r_scores_addr;
  assign bus.tx_data        = r_tx_data;
  assign bus.tx_valid       = r_tx_valid;

endmodule

`default_nettype wire
